// File: rtl/interboard_tx_sched.sv
// Transmit scheduler for the interboard link: queues game messages, gives a
// pending interboard reset message strict priority, and retries until acknowledged.
module interboard_tx_sched #(
   parameter int         DEPTH        = 4,
   parameter int         ACK_TIMEOUT  = 1000,
   parameter int         MAX_RETRY    = 3,
   parameter logic [2:0] RST_MSG_TYPE = 3'd7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rst_req,
   input  logic                     game_en,
   input  logic [2:0]               game_msg_type,
   input  logic [4:0]               game_number,
   output logic                     game_full,
   output logic [$clog2(DEPTH):0]   fifo_count,
   input  logic                     link_ready,
   input  logic                     link_ack,
   output logic                     tx_valid,
   output logic [2:0]               tx_msg_type,
   output logic [4:0]               tx_number,
   output logic                     busy,
   output logic                     overflow,
   output logic                     link_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(ACK_TIMEOUT) + 1;
   localparam int RW = $clog2(MAX_RETRY + 1) + 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            rst_pend_q, rst_pend_d;
   logic            src_rst_q, src_rst_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            tx_valid_q, tx_valid_d;
   logic [2:0]      tx_type_q, tx_type_d;
   logic [4:0]      tx_num_q, tx_num_d;
   logic            overflow_q, overflow_d;
   logic            link_err_q, link_err_d;
   logic [7:0]      mem_q [DEPTH];

   logic            full;
   logic            push_ok;
   logic            pop;
   logic            done;

   // Full is judged on pre-edge occupancy, so a push is dropped even when a pop lands in the same cycle.
   assign full    = (count_q == CW'(DEPTH));
   assign push_ok = game_en && !full;

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {game_msg_type, game_number};
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rst_pend_d = rst_pend_q;
      src_rst_d  = src_rst_q;
      retry_d    = retry_q;
      timer_d    = timer_q;
      tx_valid_d = tx_valid_q;
      tx_type_d  = tx_type_q;
      tx_num_d   = tx_num_q;
      overflow_d = overflow_q;
      link_err_d = link_err_q;
      pop        = 1'b0;
      done       = 1'b0;

      if (game_en && full) overflow_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (rst_pend_q) begin
               tx_type_d  = RST_MSG_TYPE;
               tx_num_d   = 5'd0;
               src_rst_d  = 1'b1;
               retry_d    = '0;
               tx_valid_d = 1'b1;
               state_d    = SEND;
            end else if (count_q != '0) begin
               tx_type_d  = mem_q[rd_ptr_q][7:5];
               tx_num_d   = mem_q[rd_ptr_q][4:0];
               src_rst_d  = 1'b0;
               retry_d    = '0;
               tx_valid_d = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (link_ready) begin
               tx_valid_d = 1'b0;
               timer_d    = '0;
               state_d    = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            timer_d = timer_q + 1'b1;
            // An ack arriving on the timeout cycle still counts as delivered.
            if (link_ack) begin
               done = 1'b1;
            end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d    = retry_q + 1'b1;
                  tx_valid_d = 1'b1;
                  state_d    = SEND;
               end else begin
                  done       = 1'b1;
                  link_err_d = 1'b1;
               end
            end
            if (done) begin
               state_d = IDLE;
               if (src_rst_q) rst_pend_d = 1'b0;
               else           pop        = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst_req) rst_pend_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rst_pend_q <= 1'b0;
         src_rst_q  <= 1'b0;
         retry_q    <= '0;
         timer_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_type_q  <= '0;
         tx_num_q   <= '0;
         overflow_q <= 1'b0;
         link_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rst_pend_q <= rst_pend_d;
         src_rst_q  <= src_rst_d;
         retry_q    <= retry_d;
         timer_q    <= timer_d;
         tx_valid_q <= tx_valid_d;
         tx_type_q  <= tx_type_d;
         tx_num_q   <= tx_num_d;
         overflow_q <= overflow_d;
         link_err_q <= link_err_d;
      end
   end

   assign game_full   = full;
   assign fifo_count  = count_q;
   assign tx_valid    = tx_valid_q;
   assign tx_msg_type = tx_type_q;
   assign tx_number   = tx_num_q;
   assign busy        = (state_q != IDLE) || (count_q != '0) || rst_pend_q;
   assign overflow    = overflow_q;
   assign link_err    = link_err_q;

endmodule
